// File: rtl/ad9361_lvds_nibble_tx.sv
// AD9361 LVDS-side sample source: buffers parallel 12-bit I/Q sample sets
// and serializes each set into 6-bit nibbles with the matching frame
// pattern. There is one nibble per clock. The DDR/LVDS primitives sit
// outside this block.
module ad9361_lvds_nibble_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int UFLOW_W    = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               r1_mode,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [11:0]        s_data_i0,
    input  logic [11:0]        s_data_q0,
    input  logic [11:0]        s_data_i1,
    input  logic [11:0]        s_data_q1,
    output logic               tx_frame,
    output logic [5:0]         tx_data,
    output logic               busy,
    output logic [UFLOW_W-1:0] uflow_cnt
);

    localparam int DATA_W = 12;
    localparam int SET_W  = 4 * DATA_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic             mode_q;
    logic [2:0]       beat;
    logic             last_beat;
    logic             rdy_q;

    logic [SET_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop;

    logic [SET_W-1:0]  set_p0;
    logic [SET_W-1:0]  cur_set;
    logic [DATA_W-1:0] cur_word;
    logic [5:0]        nibble;
    logic              frame_c;
    logic              set_start;

    // Saturating increment for the underflow counter.
    function automatic logic [UFLOW_W-1:0] sat_inc(input logic [UFLOW_W-1:0] v);
        return (&v) ? v : v + UFLOW_W'(1);
    endfunction

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign s_ready   = rdy_q & ~full;
    assign push      = s_valid & s_ready;
    assign set_start = (state == RUN) && (beat == 3'd0);
    assign pop       = set_start & ~empty;
    assign busy      = (state == RUN);
    assign last_beat = mode_q ? (beat == 3'd3) : (beat == 3'd7);

    // Beat 0 takes the FIFO head directly (or zeros on underflow); later
    // beats replay the set captured at beat 0.
    assign cur_set  = (beat == 3'd0) ? (empty ? '0 : fifo_mem[rd_ptr]) : set_p0;
    assign nibble   = beat[0] ? cur_word[5:0] : cur_word[11:6];
    assign frame_c  = mode_q ? (~beat[2] & ~beat[1]) : ~beat[2];

    // Select the 12-bit word for the current beat pair: i0, q0, i1, q1.
    always_comb begin
        cur_word = cur_set[DATA_W-1:0];
        case (beat[2:1])
            2'd0:    cur_word = cur_set[DATA_W-1:0];
            2'd1:    cur_word = cur_set[2*DATA_W-1:DATA_W];
            2'd2:    cur_word = cur_set[3*DATA_W-1:2*DATA_W];
            default: cur_word = cur_set[4*DATA_W-1:3*DATA_W];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: start on enable, stop only at the end of a complete set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (last_beat && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat counter; the set length is fixed by the mode captured at start-up.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat   <= 3'd0;
            mode_q <= 1'b0;
        end else if (state == IDLE) begin
            beat <= 3'd0;
            if (enable) mode_q <= r1_mode;
        end else begin
            beat <= last_beat ? 3'd0 : beat + 3'd1;
        end
    end

    // Ready is held off while reset is asserted and rises one edge after release.
    always_ff @(posedge clk) begin
        if (!resetn) rdy_q <= 1'b0;
        else         rdy_q <= 1'b1;
    end

    // FIFO storage. The data is not reset, because occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {s_data_q1, s_data_i1, s_data_q0, s_data_i0};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    // ---- stage p0: set captured at beat 0 for the remaining beats ----
    // Hold register for the set being serialized.
    always_ff @(posedge clk) begin
        if (set_start) set_p0 <= cur_set;
    end

    // ---- output stage: registered nibble and frame ----
    // Output register; forced to zero outside RUN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_data  <= 6'd0;
            tx_frame <= 1'b0;
        end else if (state == RUN) begin
            tx_data  <= nibble;
            tx_frame <= frame_c;
        end else begin
            tx_data  <= 6'd0;
            tx_frame <= 1'b0;
        end
    end

    // Underflow counter; it counts sets that started with an empty FIFO.
    always_ff @(posedge clk) begin
        if (!resetn)                uflow_cnt <= '0;
        else if (set_start && empty) uflow_cnt <= sat_inc(uflow_cnt);
    end

endmodule
